// File: rtl/ahb_arbiter.sv
// ahb_arbiter: round-robin multi-master AHB arbiter and bus mux; registered one-hot grant held through bursts.
// Optional macro AHB_ARB_STARVE_EN adds per-master wait counters that may pre-empt fixed-length bursts.
module ahb_arbiter #(
    parameter int mst_c    = 3,
    parameter int max_wait = 16
) (
    input  logic                     hclk,
    input  logic                     hreset,
    input  logic [mst_c-1:0]         hbusreq_m,
    output logic [mst_c-1:0]         hgrant_m,
    input  logic [mst_c-1:0][31:0]   haddr_m,
    input  logic [mst_c-1:0][31:0]   hwdata_m,
    input  logic [mst_c-1:0]         hwrite_m,
    input  logic [mst_c-1:0][1:0]    htrans_m,
    input  logic [mst_c-1:0][2:0]    hsize_m,
    input  logic [mst_c-1:0][2:0]    hburst_m,
    output logic [mst_c-1:0][31:0]   hrdata_m,
    output logic [mst_c-1:0][1:0]    hresp_m,
    output logic [mst_c-1:0]         hready_m,
    output logic [31:0]              haddr,
    output logic [31:0]              hwdata,
    output logic                     hwrite,
    output logic [1:0]               htrans,
    output logic [2:0]               hsize,
    output logic [2:0]               hburst,
    input  logic [31:0]              hrdata,
    input  logic [1:0]               hresp,
    input  logic                     hready,
    output logic [$clog2(mst_c)-1:0] own_id
);
    localparam int ID_W = $clog2(mst_c);

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;
    localparam logic [1:0] RSP_OKAY  = 2'b00;
    localparam logic [1:0] RSP_ERROR = 2'b01;
    localparam logic [2:0] BU_INCR   = 3'b001;

    typedef enum logic [1:0] {LK_NONE, LK_FIXED, LK_INCR} lk_e;

    lk_e             lk_q, lk_nxt;
    logic [3:0]      cnt_q, cnt_nxt;
    logic [ID_W-1:0] ptr_q, ptr_nxt;
    logic [mst_c-1:0] grant_nxt;
    logic [ID_W-1:0] dph_own;
    logic            dph_valid;
    logic            win_vld;
    logic [ID_W-1:0] win_id;
    logic            own_req;
    logic            incr_hold;

`ifdef AHB_ARB_STARVE_EN
    localparam int WC_W = $clog2(max_wait + 1);
    logic [WC_W-1:0]  wcnt_q [mst_c];
    logic [mst_c-1:0] starve;
    logic             preempt;
    logic [ID_W-1:0]  st_id;
`endif

    function automatic logic [3:0] burst_cnt(input logic [1:0] b);
        case (b)
            2'b01:   burst_cnt = 4'd3;
            2'b10:   burst_cnt = 4'd7;
            default: burst_cnt = 4'd15;
        endcase
    endfunction

    always_comb begin
        own_id = '0;
        for (int i = 0; i < mst_c; i++)
            if (hgrant_m[i]) own_id = ID_W'(i);
    end

    assign haddr  = haddr_m[own_id];
    assign hwrite = hwrite_m[own_id];
    assign hsize  = hsize_m[own_id];
    assign hburst = hburst_m[own_id];
    assign htrans = hreset ? TR_IDLE : htrans_m[own_id];
    assign hwdata = hwdata_m[dph_own];

    assign own_req   = hbusreq_m[own_id];
    assign incr_hold = own_req && (htrans != TR_IDLE) && (hburst == BU_INCR);

    always_comb begin
        for (int i = 0; i < mst_c; i++) begin
            hrdata_m[i] = hrdata;
            hready_m[i] = hready;
            hresp_m[i]  = (dph_valid && dph_own == ID_W'(i)) ? hresp : RSP_OKAY;
        end
    end

`ifdef AHB_ARB_STARVE_EN
    always_comb begin
        starve = '0;
        st_id  = '0;
        for (int i = mst_c - 1; i >= 0; i--) begin
            starve[i] = hbusreq_m[i] && (wcnt_q[i] == WC_W'(max_wait));
            if (starve[i]) st_id = ID_W'(i);
        end
    end

    // Only a fixed-length burst in its SEQ beats can be cut short.
    assign preempt = (|starve) && hready && (lk_q == LK_FIXED) &&
                     (htrans == TR_SEQ) && (hresp != RSP_ERROR);

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            for (int i = 0; i < mst_c; i++) wcnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < mst_c; i++) begin
                if (hgrant_m[i] || !hbusreq_m[i])
                    wcnt_q[i] <= '0;
                else if (wcnt_q[i] != WC_W'(max_wait))
                    wcnt_q[i] <= wcnt_q[i] + 1'b1;
            end
        end
    end
`endif

    // Burst lock FSM: fixed bursts count SEQ beats, INCR holds while the owner keeps requesting.
    always_comb begin
        lk_nxt  = lk_q;
        cnt_nxt = cnt_q;
        if (hresp == RSP_ERROR) begin
            lk_nxt  = LK_NONE;
            cnt_nxt = '0;
        end else if (hready) begin
            case (lk_q)
                LK_FIXED: begin
                    if (htrans == TR_SEQ) begin
                        if (cnt_q <= 4'd1) begin
                            cnt_nxt = '0;
                            lk_nxt  = LK_NONE;
                        end else begin
                            cnt_nxt = cnt_q - 4'd1;
                        end
                    end
                end
                LK_INCR: begin
                    if (!incr_hold) lk_nxt = LK_NONE;
                end
                default: ;
            endcase
            if (htrans == TR_NONSEQ) begin
                if (hburst[2:1] != 2'b00) begin
                    lk_nxt  = LK_FIXED;
                    cnt_nxt = burst_cnt(hburst[2:1]);
                end else if (incr_hold) begin
                    lk_nxt  = LK_INCR;
                    cnt_nxt = '0;
                end else begin
                    lk_nxt  = LK_NONE;
                    cnt_nxt = '0;
                end
            end
        end
`ifdef AHB_ARB_STARVE_EN
        if (preempt) begin
            lk_nxt  = LK_NONE;
            cnt_nxt = '0;
        end
`endif
    end

    always_comb begin
        int idx;
        win_vld = 1'b0;
        win_id  = ptr_q;
        idx     = 0;
        for (int k = 1; k <= mst_c; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= mst_c) idx = idx - mst_c;
            if (!win_vld && hbusreq_m[idx]) begin
                win_vld = 1'b1;
                win_id  = ID_W'(idx);
            end
        end
    end

    // Uses the post-update lock so a burst's last beat can hand over on the same edge.
    always_comb begin
        grant_nxt = hgrant_m;
        ptr_nxt   = ptr_q;
        if (hready && lk_nxt == LK_NONE && win_vld) begin
            grant_nxt         = '0;
            grant_nxt[win_id] = 1'b1;
            ptr_nxt           = win_id;
        end
`ifdef AHB_ARB_STARVE_EN
        if (preempt) begin
            grant_nxt        = '0;
            grant_nxt[st_id] = 1'b1;
            ptr_nxt          = st_id;
        end
`endif
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            hgrant_m  <= mst_c'(1);
            ptr_q     <= '0;
            lk_q      <= LK_NONE;
            cnt_q     <= '0;
            dph_own   <= '0;
            dph_valid <= 1'b0;
        end else begin
            hgrant_m <= grant_nxt;
            ptr_q    <= ptr_nxt;
            lk_q     <= lk_nxt;
            cnt_q    <= cnt_nxt;
            if (hready) begin
                dph_own   <= own_id;
                dph_valid <= (htrans != TR_IDLE);
            end
        end
    end

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed bench for ahb_arbiter with three masters and a small slave memory model.
module tb_ahb_arbiter;
    localparam int MST = 3;
    localparam logic [1:0] IDLE = 2'b00, NONSEQ = 2'b10, SEQ = 2'b11;
    localparam logic [1:0] OKAY = 2'b00, ERROR = 2'b01;

    logic               hclk;
    logic               hreset;
    logic [MST-1:0]       hbusreq_m;
    logic [MST-1:0]       hgrant_m;
    logic [MST-1:0][31:0] haddr_m;
    logic [MST-1:0][31:0] hwdata_m;
    logic [MST-1:0]       hwrite_m;
    logic [MST-1:0][1:0]  htrans_m;
    logic [MST-1:0][2:0]  hsize_m;
    logic [MST-1:0][2:0]  hburst_m;
    logic [MST-1:0][31:0] hrdata_m;
    logic [MST-1:0][1:0]  hresp_m;
    logic [MST-1:0]       hready_m;
    logic [31:0]        haddr, hwdata, hrdata;
    logic               hwrite, hready;
    logic [1:0]         htrans, hresp;
    logic [2:0]         hsize, hburst;
    logic [1:0]         own_id;

    int n_chk = 0;
    int n_err = 0;

    ahb_arbiter #(.mst_c(MST), .max_wait(16)) dut (
        .hclk(hclk), .hreset(hreset),
        .hbusreq_m(hbusreq_m), .hgrant_m(hgrant_m),
        .haddr_m(haddr_m), .hwdata_m(hwdata_m), .hwrite_m(hwrite_m),
        .htrans_m(htrans_m), .hsize_m(hsize_m), .hburst_m(hburst_m),
        .hrdata_m(hrdata_m), .hresp_m(hresp_m), .hready_m(hready_m),
        .haddr(haddr), .hwdata(hwdata), .hwrite(hwrite), .htrans(htrans),
        .hsize(hsize), .hburst(hburst), .hrdata(hrdata), .hresp(hresp),
        .hready(hready), .own_id(own_id)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    // Slave memory keyed by address bits [17:16] and [5:2].
    logic [31:0] mem [64];
    logic        pend_wr;
    logic [31:0] pend_addr;

    function automatic int key(input logic [31:0] a);
        return int'({a[17:16], a[5:2]});
    endfunction

    always @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            pend_wr   <= 1'b0;
            pend_addr <= '0;
            hrdata    <= '0;
            mem[1]    <= 32'h1234_5678;
        end else if (hready) begin
            if (pend_wr) mem[key(pend_addr)] <= hwdata;
            pend_wr   <= htrans[1] && hwrite;
            pend_addr <= haddr;
            if (htrans[1] && !hwrite) hrdata <= mem[key(haddr)];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    int  n;
    int  beat;
    logic got;

    initial begin
        hreset    = 1'b1;
        hbusreq_m = '1;
        htrans_m  = {MST{NONSEQ}};
        haddr_m   = '0;
        hwdata_m  = '0;
        hwrite_m  = '0;
        hsize_m   = {MST{3'b010}};
        hburst_m  = '0;
        hready    = 1'b1;
        hresp     = OKAY;

        // Reset
        repeat (2) @(posedge hclk);
        #1;
        chk("rst_grant", hgrant_m, 3'b001);
        chk("rst_htrans", htrans, IDLE);
        chk("rst_own", own_id, 0);
        hreset    = 1'b0;
        hbusreq_m = '0;
        htrans_m  = '0;
        #1;
        chk("rel_grant", hgrant_m, 3'b001);
        chk("rel_htrans", htrans, IDLE);

        // Round robin with SINGLE writes
        hbusreq_m = 3'b111;
        htrans_m  = {MST{NONSEQ}};
        hwrite_m  = 3'b111;
        haddr_m[0] = 32'h0000_0010; hwdata_m[0] = 32'hA0;
        haddr_m[1] = 32'h0001_0010; hwdata_m[1] = 32'hB1;
        haddr_m[2] = 32'h0002_0010; hwdata_m[2] = 32'hC2;
        #1;
        chk("rr_haddr0", haddr, 32'h0000_0010);
        step;
        chk("rr_grant1", hgrant_m, 3'b010);
        chk("rr_own1", own_id, 1);
        chk("rr_haddr1", haddr, 32'h0001_0010);
        chk("rr_hwdata0", hwdata, 32'hA0);
        step;
        chk("rr_grant2", hgrant_m, 3'b100);
        chk("rr_hwdata1", hwdata, 32'hB1);
        step;
        chk("rr_grant0", hgrant_m, 3'b001);
        chk("rr_hwdata2", hwdata, 32'hC2);
        hbusreq_m = '0;
        htrans_m  = '0;
        step;
        chk("park_grant", hgrant_m, 3'b001);
        chk("mem_m0", mem[key(32'h0000_0010)], 32'hA0);
        chk("mem_m1", mem[key(32'h0001_0010)], 32'hB1);
        chk("mem_m2", mem[key(32'h0002_0010)], 32'hC2);

        // INCR4 lock by master 1 while master 2 waits
        hbusreq_m[1] = 1'b1;
        step;
        chk("incr4_grant", hgrant_m, 3'b010);
        htrans_m[1] = NONSEQ; hburst_m[1] = 3'b011; haddr_m[1] = 32'h0001_0000;
        hbusreq_m[2] = 1'b1;
        for (int b = 1; b < 4; b++) begin
            step;
            chk("incr4_hold", hgrant_m, 3'b010);
            htrans_m[1] = SEQ;
            haddr_m[1]  = 32'h0001_0000 + 32'(b * 4);
        end
        step;
        chk("incr4_move", hgrant_m, 3'b100);

        // ERROR on beat 2 of master 2's INCR8, master 0 pending
        htrans_m[1] = IDLE; hbusreq_m[1] = 1'b0;
        htrans_m[2] = NONSEQ; hburst_m[2] = 3'b101; haddr_m[2] = 32'h0002_0000;
        hbusreq_m[0] = 1'b1;
        step;
        chk("incr8_lock", hgrant_m, 3'b100);
        htrans_m[2] = SEQ; haddr_m[2] = 32'h0002_0004;
        step;
        htrans_m[2] = SEQ; haddr_m[2] = 32'h0002_0008;
        hready = 1'b0;
        hresp  = ERROR;
        #1;
        chk("err_route_own", hresp_m[2], ERROR);
        chk("err_route_other", hresp_m[0], OKAY);
        step;
        chk("err_wait_grant", hgrant_m, 3'b100);
        hready = 1'b1;
        htrans_m[2] = IDLE;
        step;
        chk("err_handover", hgrant_m, 3'b001);

        // Wait states during master 0's read, master 1 requesting
        hresp = OKAY;
        hbusreq_m[2] = 1'b0;
        htrans_m[0] = NONSEQ; hburst_m[0] = 3'b000; hwrite_m[0] = 1'b0; haddr_m[0] = 32'h0000_0004;
        hbusreq_m[1] = 1'b1;
        step;
        htrans_m[0] = IDLE; hbusreq_m[0] = 1'b0;
        hbusreq_m[2] = 1'b1;
        hready = 1'b0;
        #1;
        chk("ws_ready_low", hready_m, 3'b000);
        chk("ws_grant_w1", hgrant_m, 3'b010);
        step;
        chk("ws_grant_w2", hgrant_m, 3'b010);
        step;
        chk("ws_grant_w3", hgrant_m, 3'b010);
        step;
        hready = 1'b1;
        #1;
        chk("ws_grant_end", hgrant_m, 3'b010);
        chk("ws_rdata0", hrdata_m[0], 32'h1234_5678);
        chk("ws_rdata2", hrdata_m[2], 32'h1234_5678);
        chk("ws_ready_high", hready_m, 3'b111);
        chk("ws_resp1", hresp_m[1], OKAY);
        step;
        chk("ws_after", hgrant_m, 3'b100);

`ifdef AHB_ARB_STARVE_EN
        // Master 0 streams INCR16 with early wait states; master 1 must be pre-empted in
        hbusreq_m = 3'b001;
        htrans_m[2] = IDLE;
        step;
        chk("st_grant0", hgrant_m, 3'b001);
        hbusreq_m = 3'b011;
        beat = 0;
        n    = 0;
        got  = 1'b0;
        while (!got && n < 40) begin
            htrans_m[0] = (beat == 0) ? NONSEQ : SEQ;
            hburst_m[0] = 3'b111;
            haddr_m[0]  = 32'(beat * 4);
            hready      = !(n >= 2 && n < 6);
            step;
            n++;
            if (hgrant_m[1]) got = 1'b1;
            if (hready) beat = (beat + 1) % 16;
        end
        hready = 1'b1;
        chk("st_granted", got, 1'b1);
        chk("st_latency_le17", (n <= 17), 1'b1);
`endif

        // Asynchronous reset mid-traffic
        hbusreq_m = 3'b111;
        htrans_m  = {MST{SEQ}};
        #2;
        hreset = 1'b1;
        #1;
        chk("arst_grant", hgrant_m, 3'b001);
        chk("arst_own", own_id, 0);
        chk("arst_htrans", htrans, IDLE);
        step;
        hreset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/ahb_arbiter.md
Name: ahb_arbiter

Overview:
Multi-master AHB arbiter and bus multiplexer that shares one AHB master port between mst_c requesting masters.
- Its output drives the master side of the existing ahb_router.
- Grants the address phase with a rotating (round-robin) priority and holds the grant for the length of a fixed-length burst.
- Tracks the data-phase owner so write data and responses reach the correct master.

Parameters:
mst_c, 3, number of masters (2..8)
max_wait, 16, fairness bound in cycles; used only with AHB_ARB_STARVE_EN

Ports:
hclk  in  1  AHB clock
hreset  in  1  asynchronous reset, active-high
hbusreq_m  in  [mst_c-1:0]  per-master bus request
hgrant_m  out  [mst_c-1:0]  one-hot grant, registered
haddr_m  in  [mst_c-1:0][31:0]  master address
hwdata_m  in  [mst_c-1:0][31:0]  master write data
hwrite_m  in  [mst_c-1:0]  master write
htrans_m  in  [mst_c-1:0][1:0]  master transfer type
hsize_m  in  [mst_c-1:0][2:0]  master size
hburst_m  in  [mst_c-1:0][2:0]  master burst
hrdata_m  out  [mst_c-1:0][31:0]  read data, broadcast to all masters
hresp_m  out  [mst_c-1:0][1:0]  per-master response
hready_m  out  [mst_c-1:0]  ready, broadcast to all masters
haddr  out  32  shared bus address
hwdata  out  32  shared bus write data
hwrite  out  1  shared bus write
htrans  out  2  shared bus transfer type
hsize  out  3  shared bus size
hburst  out  3  shared bus burst
hrdata  in  32  shared bus read data
hresp  in  2  shared bus response
hready  in  1  shared bus ready
own_id  out  $clog2(mst_c)  current address-phase owner, for debug

Behaviour:
- Reset (hreset=1, asynchronous):
  - hgrant_m = 'b1 (master 0 parked); own_id = 0.
  - Round-robin pointer = 0; burst counter = 0; lock = 0.
  - Data-phase owner = 0; dph_valid = 0.
  - Shared outputs follow master 0; htrans forced to IDLE (00) while hreset=1.
- Address mux (combinational): haddr/hwrite/htrans/hsize/hburst = master[own_id]'s signals. own_id is the index of the set bit in hgrant_m.
- Data-phase owner register:
  - When hready=1: dph_own <= own_id; dph_valid <= (htrans != IDLE).
  - hwdata = hwdata_m[dph_own].
- Response routing:
  - hrdata_m[i] = hrdata and hready_m[i] = hready for every i.
  - hresp_m[i] = hresp when i == dph_own and dph_valid, else OKAY (00).
- Arbitration:
  - Evaluated only when hready=1 and lock=0.
  - Winner = first requesting master scanning from (ptr+1) mod mst_c.
  - Registered: hgrant_m changes on the next hclk edge; ptr <= winner.
  - Owner still requesting and no other requester: grant is kept.
  - No requests: grant parks on the current owner, unchanged.
- Burst lock:
  - Trigger: hready=1, htrans=NONSEQ, hburst in {WRAP4/INCR4, WRAP8/INCR8, WRAP16/INCR16}.
  - Action: lock=1, counter = beats-1 (3/7/15).
  - Each hready=1 with htrans=SEQ decrements the counter; lock clears when the counter reaches 0 on that edge.
  - htrans=BUSY holds the counter unchanged.
  - INCR (001): lock=1 while the owner's hbusreq=1 and htrans in {NONSEQ, SEQ, BUSY}.
  - SINGLE: never locks.
- ERROR response:
  - hresp=ERROR (01) in any cycle clears lock and the counter.
  - Arbitration resumes at the next hready=1.
- hready=0 freezes the grant, lock, counter and data-phase owner.
- Simultaneous events:
  - Burst-end decrement to 0 and a new request in the same cycle: arbitration uses the post-decrement lock, so the grant may move on that same edge.
- Reset asserted mid-burst: immediate return to the reset state; no transfer completes.

Optional Feature:
AHB_ARB_STARVE_EN
- Defined:
  - Each non-owner master has a wait counter: increments each cycle its hbusreq=1 and it is not granted; clears when granted.
  - When any counter reaches max_wait, lock is overridden for fixed-length bursts only, at the next hready=1 with owner htrans=SEQ.
  - The grant goes to the starving master with the lowest index.
  - The pre-empted master must re-issue the remainder as NONSEQ; the arbiter makes no attempt to resume it.
- Not defined:
  - No wait counters are built; a granted burst is never pre-empted.

Test Plan:
1. Reset sequence -> after hreset=1 then release: hgrant_m=001 and htrans=00, regardless of requests.
2. Round robin:
   - Stimulus: mst_c=3; masters 0, 1, 2 each request continuously, issuing SINGLE NONSEQ writes to 0x0000_0010, 0x0001_0010, 0x0002_0010.
   - Required: grant rotates 0→1→2→0; each slave memory holds the matching data (0xA0, 0xB1, 0xC2); hwdata selects the data-phase owner.
3. INCR4 lock:
   - Stimulus: master 1 issues INCR4 from 0x0001_0000 while master 2 requests.
   - Required: hgrant_m stays 010 for 4 beats; the grant moves to master 2 on the edge completing beat 4.
4. Wait states and response routing:
   - Stimulus: slave holds hready=0 for 3 cycles during master 0's read of 0x0000_0004 while master 1 requests.
   - Required: grant frozen during the wait; hresp_m[1]=00; hrdata_m shows stored data 0x1234_5678 when hready=1.
5. ERROR mid-burst -> hresp=01 on beat 2 of master 2's INCR8: lock drops and the grant passes to the pending master 0 at the next hready=1.
6. (AHB_ARB_STARVE_EN, max_wait=16) -> master 0 runs back-to-back INCR16 while master 1 requests: master 1 is granted within 17 cycles of its request.
